hdlc_tx_buffer: RTL
===================

Name: hdlc_tx_buffer

Overview:
- TX frame buffer between the register interface and the HDLC TX serializer.
- Stores payload bytes written through the TX data register.
- On a start command, hands the bytes one at a time to the serializer using a request/data handshake.
- Reports done, full and aborted status back to the TX status/control register.

Parameters:
- DEPTH, 128, buffer capacity in bytes (power of two, 2..128).
- PTR_W, 7, pointer width, equal to log2(DEPTH).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous reset, active-low.
- Tx_WrBuff  in  1  one-cycle write strobe from the register interface.
- Tx_DataInBuff  in  8  write data; valid when Tx_WrBuff=1.
- Tx_Enable  in  1  one-cycle start-transmission pulse.
- Tx_AbortFrame  in  1  one-cycle abort pulse.
- Tx_Done  out  1  buffer idle and writable.
- Tx_Full  out  1  buffer holds DEPTH bytes.
- Tx_AbortedTrans  out  1  sticky flag: last frame was aborted.
- Tx_FrameSize  out  8  number of bytes currently stored.
- Tx_ValidFrame  out  1  frame transmission in progress (to serializer).
- Tx_Data  out  8  current byte presented to the serializer.
- Tx_LastByte  out  1  Tx_Data is the final byte of the frame.
- Tx_RdBuff  in  1  serializer pulse: current byte consumed, advance.
- Tx_AbortOut  out  1  one-cycle pulse telling the serializer to emit an abort sequence.

Behaviour:
- Reset values (async): state IDLE; wr_ptr=rd_ptr=count=0; Tx_Done=1; Tx_Full=0; Tx_AbortedTrans=0; Tx_FrameSize=0; Tx_ValidFrame=0; Tx_Data=0; Tx_LastByte=0; Tx_AbortOut=0.
- Memory contents are not reset.
- Reset asserted mid-frame drops the frame immediately, with no Tx_AbortOut pulse.
- Storage: DEPTH x 8 array, synchronous write, asynchronous read at rd_ptr.
- count is an 8-bit value in the range 0..DEPTH. Tx_FrameSize = count, zero-extended to 8 bits.
- State IDLE:
  - Tx_Done=1, Tx_ValidFrame=0.
  - Tx_WrBuff with count<DEPTH: mem[wr_ptr] <= data; wr_ptr++; count++.
  - Tx_WrBuff with count==DEPTH: byte dropped, pointers unchanged, Tx_Full stays 1.
  - Tx_Full is registered; it is high the cycle after the DEPTH-th write.
  - Tx_Enable with count>0: go to SEND; rd_ptr=0; clear Tx_AbortedTrans.
  - Tx_Enable with count==0: ignored; stay IDLE.
  - Tx_WrBuff and Tx_Enable in the same cycle: the write is performed and the start is evaluated on the pre-write count. So count==0 plus simultaneous write leaves the block in IDLE holding 1 byte.
  - Tx_AbortFrame: flush (wr_ptr=count=0). Tx_AbortedTrans unchanged; no Tx_AbortOut pulse.
- State SEND:
  - Tx_Done=0 from the cycle after the accepted Tx_Enable.
  - Tx_ValidFrame=1; Tx_Data=mem[rd_ptr]; Tx_LastByte=(rd_ptr==count-1).
  - Tx_WrBuff and Tx_Enable are ignored; writes are dropped and the buffer is not modified.
  - Tx_RdBuff and not last byte: rd_ptr++ (next byte visible the next cycle).
  - Tx_RdBuff on last byte: go to IDLE; wr_ptr=rd_ptr=count=0; Tx_Full=0; Tx_Done=1 the next cycle.
  - Tx_AbortFrame: go to IDLE; flush pointers; Tx_AbortOut=1 for exactly the next cycle; Tx_AbortedTrans=1 (sticky until the next accepted Tx_Enable).
  - Tx_AbortFrame and Tx_RdBuff in the same cycle: abort wins; the byte is not counted as sent.
- Outside SEND: Tx_Data=0 and Tx_LastByte=0.
- Throughput: one byte per Tx_RdBuff; back-to-back Tx_RdBuff on consecutive cycles is supported.

Test Plan:
- Reset mid-SEND with 3 bytes loaded -> immediately Tx_Done=1, Tx_ValidFrame=0, Tx_FrameSize=0, Tx_AbortOut never pulses.
- Write 0x7E,0x01,0xFF then Tx_Enable; serializer pulses Tx_RdBuff 3 times -> Tx_Data sequence 0x7E,0x01,0xFF; Tx_LastByte=1 only with 0xFF; Tx_Done=1 one cycle after the 3rd pulse; Tx_FrameSize=0.
- Write 129 bytes (DEPTH=128) -> Tx_Full=1 after the 128th write, Tx_FrameSize=128; the 129th byte is dropped; transmit yields 128 bytes and no 129th byte.
- Load 5 bytes, Tx_Enable, 2 Tx_RdBuff pulses, then Tx_AbortFrame -> Tx_AbortOut high for 1 cycle; Tx_AbortedTrans=1; Tx_Done=1; Tx_FrameSize=0. The next Tx_Enable with data loaded clears Tx_AbortedTrans.
- Tx_Enable with an empty buffer -> stays IDLE, Tx_ValidFrame=0. Tx_WrBuff 0x55 during SEND -> ignored; frame content and Tx_FrameSize unchanged.
- Tx_AbortFrame and Tx_RdBuff in the same cycle during SEND -> abort behaviour only; rd_ptr is not advanced and Tx_AbortOut pulses once.

Source files
------------

// File: rtl/hdlc_tx_buffer_if.sv
// Handshake bundle between the register interface, the TX frame buffer and the HDLC serializer.
// The buffer uses the slave modport; the register block and serializer side use the master modport.
interface hdlc_tx_buffer_if;
    logic       Tx_WrBuff;
    logic [7:0] Tx_DataInBuff;
    logic       Tx_Enable;
    logic       Tx_AbortFrame;
    logic       Tx_RdBuff;
    logic       Tx_Done;
    logic       Tx_Full;
    logic       Tx_AbortedTrans;
    logic [7:0] Tx_FrameSize;
    logic       Tx_ValidFrame;
    logic [7:0] Tx_Data;
    logic       Tx_LastByte;
    logic       Tx_AbortOut;

    modport slave (
        input  Tx_WrBuff, Tx_DataInBuff, Tx_Enable, Tx_AbortFrame, Tx_RdBuff,
        output Tx_Done, Tx_Full, Tx_AbortedTrans, Tx_FrameSize,
               Tx_ValidFrame, Tx_Data, Tx_LastByte, Tx_AbortOut
    );

    modport master (
        output Tx_WrBuff, Tx_DataInBuff, Tx_Enable, Tx_AbortFrame, Tx_RdBuff,
        input  Tx_Done, Tx_Full, Tx_AbortedTrans, Tx_FrameSize,
               Tx_ValidFrame, Tx_Data, Tx_LastByte, Tx_AbortOut
    );
endinterface

// File: rtl/hdlc_tx_buffer.sv
// HDLC TX frame buffer: collects payload bytes from the register interface and
// hands them to the serializer one byte per Tx_RdBuff once a frame is started.
module hdlc_tx_buffer #(
    parameter int DEPTH = 128,
    parameter int PTR_W = 7
) (
    input logic              Clk,
    input logic              Rst,
    hdlc_tx_buffer_if.slave  bus
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    state_t           state, state_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [7:0]       count, count_nxt;
    logic             full, full_nxt;
    logic             aborted, aborted_nxt;
    logic             abort_out, abort_out_nxt;
    logic             wr_en;
    logic             last_byte;
    logic [7:0]       mem [DEPTH];

    // Last byte is where the read pointer reaches the stored byte count minus one
    assign last_byte = ({{(8-PTR_W){1'b0}}, rd_ptr} == (count - 8'd1));

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count;
        aborted_nxt   = aborted;
        abort_out_nxt = 1'b0;
        wr_en         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Tx_AbortFrame) begin
                    wr_ptr_nxt = '0;
                    count_nxt  = 8'd0;
                end else begin
                    if (bus.Tx_WrBuff && (count != DEPTH_C)) begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        count_nxt  = count + 8'd1;
                    end
                    // Start is judged on the count before any same-cycle write
                    if (bus.Tx_Enable && (count != 8'd0)) begin
                        state_nxt   = SEND;
                        rd_ptr_nxt  = '0;
                        aborted_nxt = 1'b0;
                    end
                end
            end
            SEND: begin
                if (bus.Tx_AbortFrame) begin
                    state_nxt     = IDLE;
                    wr_ptr_nxt    = '0;
                    rd_ptr_nxt    = '0;
                    count_nxt     = 8'd0;
                    abort_out_nxt = 1'b1;
                    aborted_nxt   = 1'b1;
                end else if (bus.Tx_RdBuff) begin
                    if (last_byte) begin
                        state_nxt  = IDLE;
                        wr_ptr_nxt = '0;
                        rd_ptr_nxt = '0;
                        count_nxt  = 8'd0;
                    end else begin
                        rd_ptr_nxt = rd_ptr + PTR_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        full_nxt = (count_nxt == DEPTH_C);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 8'd0;
            full      <= 1'b0;
            aborted   <= 1'b0;
            abort_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            full      <= full_nxt;
            aborted   <= aborted_nxt;
            abort_out <= abort_out_nxt;
        end
    end

    // Payload storage is deliberately left unreset
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= bus.Tx_DataInBuff;
    end

    assign bus.Tx_Done         = (state == IDLE);
    assign bus.Tx_ValidFrame   = (state == SEND);
    assign bus.Tx_Full         = full;
    assign bus.Tx_AbortedTrans = aborted;
    assign bus.Tx_FrameSize    = count;
    assign bus.Tx_AbortOut     = abort_out;
    assign bus.Tx_Data         = (state == SEND) ? mem[rd_ptr] : 8'h00;
    assign bus.Tx_LastByte     = (state == SEND) && last_byte;

endmodule
